sized_data_memory: RTL and testbench



---
 rtl/data_memory_pkg.sv | 21 ++
 rtl/load_store_align.sv | 56 +++++
 rtl/sized_data_memory.sv | 90 +++++++++
 tb/tb_sized_data_memory.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types for the sized data memory: access sizes,
// sweep states and the size-to-bytes helper.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SIZE_B,
    SIZE_H,
    SIZE_W,
    SIZE_D
  } mem_size_e;

  typedef enum logic [0:0] {
    CLEAR,
    READY
  } state_e;

  function automatic int size_bytes(mem_size_e s);
    return 1 << int'(s);
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane merge for stores, extract/extend for loads,
// and alignment check for a single memory word.
module load_store_align
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int WORD_BYTES_2POW = 3,
  parameter int WORD_BYTES      = 1 << WORD_BYTES_2POW
) (
  input  logic [DATA_WIDTH-1:0]      old_word,
  input  logic [DATA_WIDTH-1:0]      store_data,
  input  logic [WORD_BYTES_2POW-1:0] offset,
  input  mem_size_e                  size,
  input  logic                       is_unsigned,
  input  logic                       merge_en,
  output logic [DATA_WIDTH-1:0]      new_word,
  output logic [DATA_WIDTH-1:0]      load_result,
  output logic                       misaligned
);

  logic [DATA_WIDTH-1:0]      shifted;
  logic [DATA_WIDTH-1:0]      src;
  logic [DATA_WIDTH-1:0]      raw;
  logic [WORD_BYTES_2POW-1:0] amask;
  int                         nb;

  always_comb begin
    nb         = size_bytes(size);
    amask      = WORD_BYTES_2POW'(nb - 1);
    misaligned = |(offset & amask);
    shifted    = store_data << {offset, 3'b000};
    new_word   = old_word;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (b >= int'(offset) && b < int'(offset) + nb)
        new_word[b*8 +: 8] = shifted[b*8 +: 8];
    end
  end

  // Write-first: a load in the same cycle as a store sees the merged word.
  assign src = merge_en ? new_word : old_word;
  assign raw = src >> {offset, 3'b000};

  always_comb begin
    load_result = raw;
    unique case (size)
      SIZE_B: load_result =
        {{(DATA_WIDTH-8){~is_unsigned & raw[7]}}, raw[7:0]};
      SIZE_H: load_result =
        {{(DATA_WIDTH-16){~is_unsigned & raw[15]}}, raw[15:0]};
      SIZE_W: load_result =
        {{(DATA_WIDTH-32){~is_unsigned & raw[31]}}, raw[31:0]};
      SIZE_D: load_result = raw;
    endcase
  end

endmodule

// File: rtl/sized_data_memory.sv
// MEM-stage data memory with sized accesses, fault detection,
// registered read port and a post-reset clear sweep.
module sized_data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int WORD_BYTES_2POW = 3,
  parameter int WORD_BYTES      = 1 << WORD_BYTES_2POW,
  parameter int DEPTH_2POW      = 6,
  parameter int DEPTH           = 1 << DEPTH_2POW
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  writeEnable_in,
  input  logic                  readEnable_in,
  input  logic [1:0]            size_in,
  input  logic                  unsigned_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fault_out,
  output logic                  busy_out
);

  localparam int HI = WORD_BYTES_2POW + DEPTH_2POW;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  state_e                     state;
  logic [DEPTH_2POW-1:0]      clear_idx;
  logic [DEPTH_2POW-1:0]      idx;
  logic [WORD_BYTES_2POW-1:0] off;
  logic                       oor;
  logic                       misaligned;
  logic                       req;
  logic                       fault;
  logic [DATA_WIDTH-1:0]      new_word;
  logic [DATA_WIDTH-1:0]      load_result;

  assign idx   = address_in[WORD_BYTES_2POW +: DEPTH_2POW];
  assign off   = address_in[WORD_BYTES_2POW-1:0];
  assign oor   = |address_in[ADDR_WIDTH-1:HI];
  assign req   = writeEnable_in | readEnable_in;
  assign fault = req & (oor | misaligned);

  load_store_align #(
    .DATA_WIDTH      (DATA_WIDTH),
    .WORD_BYTES_2POW (WORD_BYTES_2POW),
    .WORD_BYTES      (WORD_BYTES)
  ) u_align (
    .old_word    (mem[idx]),
    .store_data  (data_in),
    .offset      (off),
    .size        (mem_size_e'(size_in)),
    .is_unsigned (unsigned_in),
    .merge_en    (writeEnable_in),
    .new_word    (new_word),
    .load_result (load_result),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      data_out  <= '0;
      fault_out <= 1'b0;
      busy_out  <= 1'b1;
      state     <= CLEAR;
      clear_idx <= '0;
      mem[0]    <= '0;
    end else if (state == CLEAR) begin
      mem[clear_idx] <= '0;
      clear_idx      <= clear_idx + 1'b1;
      data_out       <= '0;
      fault_out      <= 1'b0;
      if (clear_idx == '1) begin
        state    <= READY;
        busy_out <= 1'b0;
      end
    end else begin
      fault_out <= fault;
      if (fault)
        data_out <= '0;
      else if (readEnable_in)
        data_out <= load_result;
      if (writeEnable_in && !fault)
        mem[idx] <= new_word;
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// Randomised self-checking bench for sized_data_memory
// against a byte-array reference model.
module tb_sized_data_memory;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [63:0] address_in;
  logic [63:0] data_in;
  logic        writeEnable_in;
  logic        readEnable_in;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic [63:0] data_out;
  logic        fault_out;
  logic        busy_out;

  int total = 0;
  int bad   = 0;

  logic [7:0]  model [512];
  logic [63:0] exp_dout;
  logic        exp_fault;

  always #5 clk_in = ~clk_in;

  sized_data_memory dut (
    .clk_in         (clk_in),
    .reset          (reset),
    .address_in     (address_in),
    .data_in        (data_in),
    .writeEnable_in (writeEnable_in),
    .readEnable_in  (readEnable_in),
    .size_in        (size_in),
    .unsigned_in    (unsigned_in),
    .data_out       (data_out),
    .fault_out      (fault_out),
    .busy_out       (busy_out)
  );

  task automatic model_clear();
    for (int i = 0; i < 512; i++) model[i] = 8'h00;
    exp_dout  = '0;
    exp_fault = 1'b0;
  endtask

  task automatic model_op(input logic [63:0] a, input logic [63:0] d,
                          input bit w, input bit r,
                          input int sz, input bit u);
    int nb;
    logic [63:0] v;
    logic [63:0] ones;
    nb = 1 << sz;
    ones = '1;
    if ((w || r) && (a >= 64'd512 || (a % nb) != 0)) begin
      exp_dout  = '0;
      exp_fault = 1'b1;
    end else begin
      exp_fault = 1'b0;
      if (w)
        for (int i = 0; i < nb; i++) model[a + i] = d[i*8 +: 8];
      if (r) begin
        v = '0;
        for (int i = 0; i < nb; i++) v |= 64'(model[a + i]) << (8 * i);
        if (!u && sz != 3 && v[8*nb-1]) v |= ones << (8 * nb);
        exp_dout = v;
      end
    end
  endtask

  task automatic op(input logic [63:0] a, input logic [63:0] d,
                    input bit w, input bit r, input int sz, input bit u);
    model_op(a, d, w, r, sz, u);
    address_in     = a;
    data_in        = d;
    writeEnable_in = w;
    readEnable_in  = r;
    size_in        = 2'(sz);
    unsigned_in    = u;
    @(posedge clk_in);
    #1;
    writeEnable_in = 1'b0;
    readEnable_in  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic count_sweep(input string name);
    int cnt;
    bit ignored_ok;
    cnt = 0;
    ignored_ok = 1'b1;
    reset = 1'b0;
    address_in = 64'h3;
    data_in = '1;
    writeEnable_in = 1'b1;
    readEnable_in = 1'b1;
    size_in = 2'd1;
    while (busy_out === 1'b1 && cnt < 200) begin
      cnt++;
      if (data_out !== 64'h0 || fault_out !== 1'b0) ignored_ok = 1'b0;
      @(posedge clk_in);
      #1;
    end
    writeEnable_in = 1'b0;
    readEnable_in = 1'b0;
    model_clear();
    total++;
    if (cnt !== 64) begin
      bad++;
      $display("FAIL %s busy_cycles got=%0d want=64", name, cnt);
    end
    total++;
    if (!ignored_ok) begin
      bad++;
      $display("FAIL %s sweep_ignore got=nonzero output want=0", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_cycle();
    total++;
    if (busy_out !== 1'b1 || data_out !== 64'h0 || fault_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got busy=%b dout=%h fault=%b want 1/0/0",
               busy_out, data_out, fault_out);
    end
    count_sweep("test_reset");
    op(64'h1F8, 0, 0, 1, 3, 0);
    total++;
    if (data_out !== 64'h0 || fault_out !== 1'b0) begin
      bad++;
      $display("FAIL read_1f8 got=%h/%b want=0/0", data_out, fault_out);
    end
  endtask

  task automatic test_merge();
    op(64'h08, 64'h1122334455667788, 1, 0, 3, 0);
    op(64'h0B, 64'hAB, 1, 0, 0, 0);
    op(64'h08, 0, 0, 1, 3, 0);
    total++;
    if (data_out !== 64'h11223344AB667788 || data_out !== exp_dout) begin
      bad++;
      $display("FAIL byte_merge got=%h want=11223344ab667788", data_out);
    end
    op(64'h0B, 0, 0, 1, 0, 0);
    total++;
    if (data_out !== 64'hFFFFFFFFFFFFFFAB) begin
      bad++;
      $display("FAIL load_byte got=%h want=ffffffffffffffab", data_out);
    end
    idle_cycle();
    total++;
    if (data_out !== 64'hFFFFFFFFFFFFFFAB || fault_out !== 1'b0) begin
      bad++;
      $display("FAIL hold got=%h/%b want=ffffffffffffffab/0",
               data_out, fault_out);
    end
  endtask

  task automatic test_sign();
    op(64'h10, 64'h80000001, 1, 0, 2, 0);
    op(64'h10, 0, 0, 1, 2, 0);
    total++;
    if (data_out !== 64'hFFFFFFFF80000001) begin
      bad++;
      $display("FAIL load_w_signed got=%h want=ffffffff80000001", data_out);
    end
    op(64'h10, 0, 0, 1, 2, 1);
    total++;
    if (data_out !== 64'h0000000080000001) begin
      bad++;
      $display("FAIL load_w_unsigned got=%h want=0000000080000001", data_out);
    end
  endtask

  task automatic test_fault();
    op(64'h03, 0, 0, 1, 1, 0);
    total++;
    if (fault_out !== 1'b1 || data_out !== 64'h0) begin
      bad++;
      $display("FAIL misaligned_h got=%h/%b want=0/1", data_out, fault_out);
    end
    op(64'h0C, 64'hDEADBEEF, 1, 0, 2, 0);
    total++;
    if (fault_out !== 1'b0) begin
      bad++;
      $display("FAIL store_w_ok fault got=%b want=0", fault_out);
    end
    op(64'h0C, 64'h0123456789ABCDEF, 1, 0, 3, 0);
    total++;
    if (fault_out !== 1'b1 || data_out !== 64'h0) begin
      bad++;
      $display("FAIL misaligned_d got=%h/%b want=0/1", data_out, fault_out);
    end
    op(64'h0C, 0, 0, 1, 2, 0);
    total++;
    if (data_out !== 64'hFFFFFFFFDEADBEEF || fault_out !== 1'b0) begin
      bad++;
      $display("FAIL after_fault got=%h want=ffffffffdeadbeef", data_out);
    end
  endtask

  task automatic test_oor();
    op(64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 3, 0);
    total++;
    if (fault_out !== 1'b1 || data_out !== 64'h0) begin
      bad++;
      $display("FAIL oor_store got=%h/%b want=0/1", data_out, fault_out);
    end
    for (int i = 0; i < 64; i++) begin
      op(64'(i * 8), 0, 0, 1, 3, 0);
      total++;
      if (data_out !== exp_dout || fault_out !== 1'b0) begin
        bad++;
        $display("FAIL readback_%0d got=%h want=%h", i, data_out, exp_dout);
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) idle_cycle();
    total++;
    if (busy_out !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy got=%b want=1", busy_out);
    end
    reset = 1'b1;
    idle_cycle();
    count_sweep("test_reset_mid");
    op(64'h20, 64'h5, 1, 1, 3, 0);
    total++;
    if (data_out !== 64'h5 || fault_out !== 1'b0) begin
      bad++;
      $display("FAIL write_first got=%h want=5", data_out);
    end
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [63:0] d;
    int sz;
    bit w;
    bit r;
    bit u;
    for (int n = 0; n < 400; n++) begin
      sz = int'($urandom_range(0, 3));
      a  = 64'($urandom_range(0, 32'h21F));
      if ($urandom_range(0, 3) != 0) a &= ~64'((1 << sz) - 1);
      d  = {$urandom, $urandom};
      w  = 1'($urandom);
      r  = 1'($urandom);
      u  = 1'($urandom);
      op(a, d, w, r, sz, u);
      total++;
      if (data_out !== exp_dout || fault_out !== exp_fault ||
          busy_out !== 1'b0) begin
        bad++;
        $display("FAIL random_%0d a=%h sz=%0d w=%b r=%b got=%h/%b want=%h/%b",
                 n, a, sz, w, r, data_out, fault_out, exp_dout, exp_fault);
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    address_in     = '0;
    data_in        = '0;
    writeEnable_in = 1'b0;
    readEnable_in  = 1'b0;
    size_in        = 2'd0;
    unsigned_in    = 1'b0;
    model_clear();
    #2;
    test_reset();
    test_merge();
    test_sign();
    test_fault();
    test_oor();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
